matrix_stream_feeder: RTL and testbench

Synthesizable, parametrised matrix stream source that feeds the matrix-processing core. Holds `NUM_MATS` matrices of `ELEMS` elements each in an internal buffer loaded through a write port. On `start`, it streams them one matrix at a time over a valid/ready interface. It waits for the core's `finish` between matrices and can optionally loop continuously.

---
 rtl/matrix_stream_feeder_if.sv | 35 +++
 rtl/matrix_stream_feeder.sv | 101 ++++++++++
 tb/tb_matrix_stream_feeder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_feeder_if.sv
// Bus bundle for matrix_stream_feeder: buffer write port, run control and
// the valid/ready element stream with its per-matrix finish handshake.
interface matrix_stream_feeder_if #(
  parameter int DATA_W   = 8,
  parameter int ELEMS    = 32,
  parameter int NUM_MATS = 2,
  parameter int ADDR_W   = $clog2(ELEMS * NUM_MATS),
  parameter int MIDX_W   = $clog2(NUM_MATS) + 1
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              loop_mode;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              finish;
  logic              busy;
  logic [MIDX_W-1:0] mat_idx;
  logic              done;
  logic              wr_err;

  modport master (
    input  wr_en, wr_addr, wr_data, start, loop_mode, abort, out_ready, finish,
    output out_valid, out_data, out_last, busy, mat_idx, done, wr_err
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, loop_mode, abort, out_ready, finish,
    input  out_valid, out_data, out_last, busy, mat_idx, done, wr_err
  );
endinterface

// File: rtl/matrix_stream_feeder.sv
// Buffered matrix source: streams NUM_MATS matrices of ELEMS elements each,
// waiting for the consumer's finish between matrices, optionally looping.
module matrix_stream_feeder #(
  parameter int DATA_W   = 8,
  parameter int ELEMS    = 32,
  parameter int NUM_MATS = 2,
  parameter int ADDR_W   = $clog2(ELEMS * NUM_MATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_stream_feeder_if.master bus
);
  localparam int          EW    = $clog2(ELEMS);
  localparam int          MW    = $clog2(NUM_MATS) + 1;
  localparam int unsigned DEPTH = ELEMS * NUM_MATS;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_FIN, DONE} state_t;

  state_t            r_state;
  logic [EW-1:0]     r_elem_cnt;
  logic [MW-1:0]     r_mat_idx;
  logic              r_loop;
  logic              r_wr_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_stream;
  logic              w_last;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_stream  = (r_state == STREAM);
  assign w_last    = w_stream && (r_elem_cnt == EW'(ELEMS - 1));
  assign w_rd_addr = ADDR_W'(32'(r_mat_idx) * ELEMS + 32'(r_elem_cnt));
  assign w_wr_ok   = bus.wr_en && !rst && (r_state == IDLE) &&
                     (32'(bus.wr_addr) < DEPTH);

  // Buffer survives reset and abort, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_elem_cnt <= '0;
      r_mat_idx  <= '0;
      r_loop     <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err <= bus.wr_en && !w_wr_ok;
      if (bus.abort) begin
        r_state    <= IDLE;
        r_elem_cnt <= '0;
        r_mat_idx  <= '0;
        r_loop     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_elem_cnt <= '0;
            r_mat_idx  <= '0;
            r_loop     <= bus.loop_mode;
            if (bus.start) r_state <= STREAM;
          end
          STREAM: begin
            // ELEMS is a power of two, so the counter wraps to 0 on the last element.
            if (bus.out_ready) begin
              r_elem_cnt <= r_elem_cnt + EW'(1);
              if (w_last) r_state <= WAIT_FIN;
            end
          end
          WAIT_FIN: begin
            if (bus.finish) begin
              if (32'(r_mat_idx) < NUM_MATS - 1) begin
                r_mat_idx <= r_mat_idx + MW'(1);
                r_state   <= STREAM;
              end else if (r_loop) begin
                r_mat_idx <= '0;
                r_state   <= STREAM;
              end else begin
                r_state <= DONE;
              end
            end
          end
          DONE: begin
            r_mat_idx <= '0;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = w_stream;
  assign bus.out_data  = w_stream ? r_mem[w_rd_addr] : '0;
  assign bus.out_last  = w_last;
  assign bus.busy      = (r_state != IDLE);
  assign bus.mat_idx   = r_mat_idx;
  assign bus.done      = (r_state == DONE);
  assign bus.wr_err    = r_wr_err;
endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Bench for matrix_stream_feeder: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the run sequence.
module tb_matrix_stream_feeder;
  localparam int DW = 8;
  localparam int EL = 32;
  localparam int NM = 2;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_stream_feeder_if #(.DATA_W(DW), .ELEMS(EL), .NUM_MATS(NM)) bus ();
  matrix_stream_feeder #(.DATA_W(DW), .ELEMS(EL), .NUM_MATS(NM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  matrix_stream_feeder_if #(.DATA_W(16), .ELEMS(2), .NUM_MATS(1)) sb ();
  matrix_stream_feeder #(.DATA_W(16), .ELEMS(2), .NUM_MATS(1)) sdut (
    .clk(clk), .rst(rst), .bus(sb)
  );

  typedef enum {M_IDLE, M_STREAM, M_WAIT, M_DONE} mph_t;

  mph_t          m_ph   = M_IDLE;
  int            m_mat  = 0;
  int            m_elem = 0;
  bit            m_loop = 1'b0;
  bit            m_werr = 1'b0;
  logic [DW-1:0] shadow [EL*NM];

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int fin_cd = -1;
  int kk     = 0;
  logic [DW-1:0] got  [$];
  bit            gotl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    m_werr = 1'b0;
    if (rst) begin
      m_ph = M_IDLE; m_mat = 0; m_elem = 0;
      return;
    end
    if (bus.wr_en) begin
      if (m_ph == M_IDLE) shadow[bus.wr_addr] = bus.wr_data;
      else m_werr = 1'b1;
    end
    if (bus.abort) begin
      m_ph = M_IDLE; m_mat = 0; m_elem = 0;
      return;
    end
    case (m_ph)
      M_IDLE: if (bus.start) begin m_ph = M_STREAM; m_loop = bus.loop_mode; end
      M_STREAM: if (bus.out_ready) begin
        m_elem++;
        if (m_elem == EL) begin m_elem = 0; m_ph = M_WAIT; end
      end
      M_WAIT: if (bus.finish) begin
        if (m_mat < NM - 1) begin m_mat++; m_ph = M_STREAM; end
        else if (m_loop) begin m_mat = 0; m_ph = M_STREAM; end
        else m_ph = M_DONE;
      end
      M_DONE: begin m_ph = M_IDLE; m_mat = 0; end
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic check();
    bit v;
    v = (m_ph == M_STREAM);
    chk("out_valid", bus.out_valid, v);
    chk("out_data", bus.out_data, v ? shadow[m_mat*EL + m_elem] : 8'h00);
    chk("out_last", bus.out_last, v && (m_elem == EL - 1));
    chk("busy", bus.busy, m_ph != M_IDLE);
    chk("mat_idx", bus.mat_idx, m_mat);
    chk("done", bus.done, m_ph == M_DONE);
    chk("wr_err", bus.wr_err, m_werr);
    if (bus.done === 1'b1) n_done++;
  endtask

  // One clock: record a transfer about to happen, step the model, compare at negedge.
  task automatic cyc();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got.push_back(bus.out_data);
      gotl.push_back(bus.out_last);
    end
    model_step();
    @(negedge clk);
    check();
  endtask

  task automatic resp_cyc(input int rmode);
    bus.out_ready = (rmode == 0) ? 1'b1 : ((kk % 3) == 0);
    kk++;
    if (m_ph == M_WAIT && fin_cd < 0) fin_cd = 3;
    bus.finish = (fin_cd == 0);
    if (fin_cd >= 0) fin_cd--;
    cyc();
  endtask

  task automatic run_to_idle(input string nm, input int rmode);
    bit ok;
    ok = 1'b0; fin_cd = -1; kk = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      resp_cyc(rmode);
      ok = (m_ph == M_IDLE);
    end
    bus.finish = 1'b0; bus.out_ready = 1'b0;
    chk(nm, ok, 1);
  endtask

  task automatic start_run(input bit lp);
    bus.start = 1'b1; bus.loop_mode = lp;
    cyc();
    bus.start = 1'b0; bus.loop_mode = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   ok;
    bit   seq_ok;
    int   pm;
    mph_t pp;
    rst = 1'b1;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0;
    bus.loop_mode = 0; bus.abort = 0; bus.out_ready = 0; bus.finish = 0;
    sb.wr_en = 0; sb.wr_addr = '0; sb.wr_data = '0; sb.start = 0;
    sb.loop_mode = 0; sb.abort = 0; sb.out_ready = 0; sb.finish = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mat", bus.mat_idx, 0);

    for (int i = 0; i < EL*NM; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(i + 1);
      cyc();
    end
    bus.wr_en = 1'b0;

    // Basic run
    got.delete(); gotl.delete(); n_done = 0;
    start_run(1'b0);
    chk("start_latency", bus.out_valid, 1);
    run_to_idle("basic_timeout", 0);
    chk("basic_count", got.size(), 64);
    chk("basic_first", got[0], 1);
    chk("basic_e32", got[31], 32);
    chk("basic_last32", gotl[31], 1);
    chk("basic_last31", gotl[30], 0);
    chk("basic_e33", got[32], 33);
    chk("basic_e64", got[63], 64);
    chk("basic_done", n_done, 1);

    // Backpressure
    got.delete(); gotl.delete();
    start_run(1'b0);
    run_to_idle("bp_timeout", 1);
    chk("bp_count", got.size(), 64);
    seq_ok = 1'b1;
    foreach (got[i]) if (got[i] !== DW'(i + 1)) seq_ok = 1'b0;
    chk("bp_seq", seq_ok, 1);

    // Spurious finish, start and write while busy
    got.delete(); gotl.delete();
    start_run(1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    bus.finish = 1'b1; cyc(); bus.finish = 1'b0;
    chk("fin_in_stream", bus.out_data, 7);
    for (int c = 0; c < 100 && m_ph != M_WAIT; c++) cyc();
    bus.out_ready = 1'b0;
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 8'hAA;
    cyc();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk("wr_err_busy", bus.wr_err, 1);
    chk("start_in_wait", bus.out_valid, 0);
    cyc();
    chk("wr_err_pulse", bus.wr_err, 0);
    chk("wait_busy", bus.busy, 1);
    run_to_idle("spur_timeout", 0);

    // Reset mid-stream
    got.delete(); gotl.delete();
    start_run(1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && got.size() < 16; c++) cyc();
    chk("mid_e17", bus.out_data, 17);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_busy", bus.busy, 0);
    bus.out_ready = 1'b0;
    got.delete(); gotl.delete();
    start_run(1'b0);
    run_to_idle("replay_timeout", 0);
    chk("replay_first", got[0], 1);
    chk("replay_e6_kept", got[5], 6);
    chk("replay_count", got.size(), 64);

    // Loop mode, then abort
    n_done = 0; fin_cd = -1; kk = 0; ok = 1'b0;
    start_run(1'b1);
    for (int c = 0; c < 400 && !ok; c++) begin
      pm = m_mat; pp = m_ph;
      resp_cyc(0);
      ok = (pp == M_WAIT && pm == NM - 1 && m_ph == M_STREAM);
    end
    bus.finish = 1'b0; bus.out_ready = 1'b0;
    chk("loop_timeout", ok, 1);
    chk("loop_data", bus.out_data, 1);
    chk("loop_mat", bus.mat_idx, 0);
    chk("loop_nodone", n_done, 0);
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    bus.abort = 1'b1; bus.start = 1'b1; cyc(); bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_start", bus.busy, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.loop_mode = 1'($urandom_range(0, 1));
      bus.abort     = ($urandom_range(0, 149) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.finish    = ($urandom_range(0, 3) == 0);
      bus.wr_en     = ($urandom_range(0, 9) == 0);
      bus.wr_addr   = AW'($urandom_range(0, EL*NM - 1));
      bus.wr_data   = DW'($urandom);
      cyc();
    end
    rst = 1'b0;
    bus.start = 0; bus.abort = 0; bus.out_ready = 0; bus.finish = 0; bus.wr_en = 0;
    cyc();

    // Edge parameters: one 2-element matrix, 16-bit data
    sb.wr_en = 1'b1; sb.wr_addr = 1'b0; sb.wr_data = 16'h1234; cyc();
    sb.wr_addr = 1'b1; sb.wr_data = 16'hFFFF; cyc();
    sb.wr_en = 1'b0; sb.start = 1'b1; cyc(); sb.start = 1'b0;
    chk("s_valid0", sb.out_valid, 1);
    chk("s_data0", sb.out_data, 16'h1234);
    chk("s_last0", sb.out_last, 0);
    sb.out_ready = 1'b1; cyc();
    chk("s_data1", sb.out_data, 16'hFFFF);
    chk("s_last1", sb.out_last, 1);
    cyc();
    chk("s_wait_valid", sb.out_valid, 0);
    chk("s_wait_busy", sb.busy, 1);
    sb.out_ready = 1'b0; sb.finish = 1'b1; cyc(); sb.finish = 1'b0;
    chk("s_done", sb.done, 1);
    cyc();
    chk("s_done_end", sb.done, 0);
    chk("s_idle", sb.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
